// File: rtl/intpol2_d4_ctrl.sv
// intpol2_d4_ctrl: FSM sequencer for the quadratic interpolation datapath.
// Loads a three-sample window (m0/m1/m2), then produces cfg_intpol output
// samples per window. It slides the window one sample at a time until
// cfg_n_samples inputs have been consumed. Only strobes are driven here.
// Build option: define INTPOL2_CTRL_BACKPRESSURE_EN to honour out_ready.
// Without it, every output is taken as accepted in its single OUT cycle.
module intpol2_d4_ctrl #(
  parameter int CNT_W = 16,
  parameter int L_W   = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_n_samples,
  input  logic [L_W-1:0]   cfg_intpol,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             Ld_M0,
  output logic             Ld_M1,
  output logic             Ld_M2,
  output logic             en_stream,
  output logic             op_1,
  output logic             clear,
  output logic             en_sum,
  output logic [1:0]       sel_xi2,
  output logic             sel_mult,
  output logic             Ld_p1_xi,
  output logic             Ld_data
);

  typedef enum logic [3:0] {
    IDLE,
    LOAD0,
    LOAD1,
    LOAD2,
    COEF,
    MUL1,
    MUL2,
    OUT,
    STREAM,
    DONE
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] n_cfg;
  logic [CNT_W-1:0] consumed;
  logic [L_W-1:0]   l_cfg;
  logic [L_W-1:0]   idx;
  logic             cfg_ok;
  logic             accept_start;
  logic             last_idx;
  logic             out_hs;
  logic             take_sample;

  assign cfg_ok       = (cfg_n_samples >= CNT_W'(3)) && (cfg_intpol != '0);
  assign accept_start = (state == IDLE) && start && cfg_ok;
  assign last_idx     = (idx == (l_cfg - L_W'(1)));
  assign take_sample  = Ld_M0 | Ld_M1 | Ld_M2 | en_stream;
  assign busy         = (state != IDLE);

`ifdef INTPOL2_CTRL_BACKPRESSURE_EN
  assign out_hs = out_ready;
`else
  logic unused_out_ready;
  assign unused_out_ready = out_ready;
  assign out_hs = 1'b1;
`endif

  // State register; an asynchronous reset abandons the run with no done pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Latch the run configuration on an accepted start and keep the sticky error
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      n_cfg <= '0;
      l_cfg <= '0;
      err   <= 1'b0;
    end else if ((state == IDLE) && start) begin
      if (cfg_ok) begin
        n_cfg <= cfg_n_samples;
        l_cfg <= cfg_intpol;
        err   <= 1'b0;
      end else begin
        err <= 1'b1;
      end
    end
  end

  // Count input samples consumed in this run (window loads plus stream shifts)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      consumed <= '0;
    end else if (accept_start) begin
      consumed <= '0;
    end else if (take_sample) begin
      consumed <= consumed + CNT_W'(1);
    end
  end

  // Sub-sample index within the current window, restarted with the coefficients
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (en_sum) begin
      idx <= idx + L_W'(1);
    end
  end

  // Next-state and strobe decode: Moore strobes per state, with the window
  // loads gated by s_valid and the accumulator step gated by the out handshake
  always_comb begin
    next_state = state;
    s_ready    = 1'b0;
    out_valid  = 1'b0;
    done       = 1'b0;
    Ld_M0      = 1'b0;
    Ld_M1      = 1'b0;
    Ld_M2      = 1'b0;
    en_stream  = 1'b0;
    op_1       = 1'b0;
    clear      = 1'b0;
    en_sum     = 1'b0;
    sel_xi2    = 2'b00;
    sel_mult   = 1'b0;
    Ld_p1_xi   = 1'b0;
    Ld_data    = 1'b0;
    case (state)
      IDLE: begin
        if (accept_start) begin
          next_state = LOAD0;
        end
      end
      LOAD0: begin
        s_ready = 1'b1;
        if (s_valid) begin
          Ld_M0      = 1'b1;
          next_state = LOAD1;
        end
      end
      LOAD1: begin
        s_ready = 1'b1;
        if (s_valid) begin
          Ld_M1      = 1'b1;
          next_state = LOAD2;
        end
      end
      LOAD2: begin
        s_ready = 1'b1;
        if (s_valid) begin
          Ld_M2      = 1'b1;
          next_state = COEF;
        end
      end
      COEF: begin
        op_1       = 1'b1;
        clear      = 1'b1;
        next_state = MUL1;
      end
      MUL1: begin
        Ld_p1_xi   = 1'b1;
        next_state = MUL2;
      end
      MUL2: begin
        sel_mult   = 1'b1;
        Ld_data    = 1'b1;
        next_state = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_hs) begin
          if (!last_idx) begin
            en_sum     = 1'b1;
            sel_xi2    = (idx == '0) ? 2'b01 : 2'b10;
            next_state = MUL1;
          end else if (consumed == n_cfg) begin
            next_state = DONE;
          end else begin
            next_state = STREAM;
          end
        end
      end
      STREAM: begin
        s_ready = 1'b1;
        if (s_valid) begin
          en_stream  = 1'b1;
          next_state = COEF;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule
